// File: rtl/display_entry_ctrl.sv
// Keypad entry sequencer and message arbiter driving a 4-digit seven-segment multiplexer.
// A system message preempts the entry view for MSG_HOLD cycles; the entry buffer is preserved meanwhile.
module display_entry_ctrl #(
    parameter int BLINK_DIV = 25000000,
    parameter int MSG_HOLD  = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    output logic        msg_ack,
    output logic [3:0]  hexa3,
    output logic [3:0]  hexa2,
    output logic [3:0]  hexa1,
    output logic [3:0]  hexa0,
    output logic [3:0]  puntos4,
    output logic [15:0] value_out,
    output logic        value_valid,
    output logic [2:0]  digit_count,
    output logic        msg_active
);

    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int HW = (MSG_HOLD > 1) ? $clog2(MSG_HOLD) : 1;
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);
    localparam logic [HW-1:0] HOLD_TOP  = HW'(MSG_HOLD - 1);

    typedef enum logic [0:0] {ST_ENTRY = 1'b0, ST_MSG = 1'b1} state_t;

    state_t         state_r, state_s;
    logic [15:0]    entry_r, entry_s;
    logic [2:0]     count_r, count_s;
    logic [15:0]    msg_r, msg_s;
    logic [HW-1:0]  hold_r, hold_s;
    logic           blink_r, blink_s;
    logic [BW-1:0]  bcnt_r, bcnt_s;
    logic [15:0]    value_s;
    logic           vvalid_s;
    logic           ack_s;
    logic           key_acc_s;
    logic [15:0]    disp_s;
    logic [3:0]     dots_s;

    // Next-state computation for entry buffer, message arbitration and cursor blink
    always_comb begin
        state_s   = state_r;
        entry_s   = entry_r;
        count_s   = count_r;
        msg_s     = msg_r;
        hold_s    = hold_r;
        value_s   = value_out;
        vvalid_s  = 1'b0;
        ack_s     = 1'b0;
        key_acc_s = 1'b0;

        if (bcnt_r == BLINK_TOP) begin
            bcnt_s  = '0;
            blink_s = ~blink_r;
        end else begin
            bcnt_s  = bcnt_r + {{(BW-1){1'b0}}, 1'b1};
            blink_s = blink_r;
        end

        case (state_r)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (!key_code[4]) begin
                        if (count_r < 3'd4) begin
                            entry_s   = {entry_r[11:0], key_code[3:0]};
                            count_s   = count_r + 3'd1;
                            key_acc_s = 1'b1;
                        end else begin
                            key_acc_s = 1'b0;
                        end
                    end else begin
                        case (key_code[3:0])
                            4'h0: begin
                                entry_s   = 16'h0000;
                                count_s   = 3'd0;
                                key_acc_s = 1'b1;
                            end
                            4'h1: begin
                                if (count_r != 3'd0) begin
                                    entry_s   = {4'h0, entry_r[15:4]};
                                    count_s   = count_r - 3'd1;
                                    key_acc_s = 1'b1;
                                end else begin
                                    key_acc_s = 1'b0;
                                end
                            end
                            4'h2: begin
                                value_s   = entry_r;
                                vvalid_s  = 1'b1;
                                entry_s   = 16'h0000;
                                count_s   = 3'd0;
                                key_acc_s = 1'b1;
                            end
                            default: key_acc_s = 1'b0;
                        endcase
                    end
                end else begin
                    key_acc_s = 1'b0;
                end
                // Message acceptance happens on the same edge as any key above
                if (msg_req) begin
                    msg_s   = msg_data;
                    ack_s   = 1'b1;
                    hold_s  = HOLD_TOP;
                    state_s = ST_MSG;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_MSG: begin
                if (msg_req) begin
                    msg_s   = msg_data;
                    ack_s   = 1'b1;
                    hold_s  = HOLD_TOP;
                end else if (hold_r == '0) begin
                    state_s = ST_ENTRY;
                end else begin
                    hold_s  = hold_r - {{(HW-1){1'b0}}, 1'b1};
                end
            end
            default: state_s = ST_ENTRY;
        endcase

        if (key_acc_s) begin
            blink_s = 1'b1;
            bcnt_s  = '0;
        end else begin
            key_acc_s = 1'b0;
        end

        if (state_s == ST_MSG) begin
            disp_s = msg_s;
            dots_s = 4'b1111;
        end else if (count_s == 3'd4) begin
            disp_s = entry_s;
            dots_s = 4'b0000;
        end else begin
            disp_s = entry_s;
            dots_s = {3'b000, blink_s};
        end
    end

    // State and registered outputs; reset drops any message and clears the entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_ENTRY;
            entry_r     <= 16'h0000;
            count_r     <= 3'd0;
            msg_r       <= 16'h0000;
            hold_r      <= '0;
            blink_r     <= 1'b1;
            bcnt_r      <= '0;
            value_out   <= 16'h0000;
            value_valid <= 1'b0;
            msg_ack     <= 1'b0;
            msg_active  <= 1'b0;
            {hexa3, hexa2, hexa1, hexa0} <= 16'h0000;
            puntos4     <= 4'b0001;
            digit_count <= 3'd0;
        end else begin
            state_r     <= state_s;
            entry_r     <= entry_s;
            count_r     <= count_s;
            msg_r       <= msg_s;
            hold_r      <= hold_s;
            blink_r     <= blink_s;
            bcnt_r      <= bcnt_s;
            value_out   <= value_s;
            value_valid <= vvalid_s;
            msg_ack     <= ack_s;
            msg_active  <= (state_s == ST_MSG);
            {hexa3, hexa2, hexa1, hexa0} <= disp_s;
            puntos4     <= dots_s;
            digit_count <= count_s;
        end
    end

endmodule

// File: tb/tb_display_entry_ctrl.sv
// Scoreboard bench for display_entry_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_display_entry_ctrl;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        msg_req;
    logic [15:0] msg_data;
    logic        msg_ack;
    logic [3:0]  hexa3, hexa2, hexa1, hexa0;
    logic [3:0]  puntos4;
    logic [15:0] value_out;
    logic        value_valid;
    logic [2:0]  digit_count;
    logic        msg_active;

    display_entry_ctrl #(.BLINK_DIV(4), .MSG_HOLD(8)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .msg_req(msg_req), .msg_data(msg_data), .msg_ack(msg_ack),
        .hexa3(hexa3), .hexa2(hexa2), .hexa1(hexa1), .hexa0(hexa0),
        .puntos4(puntos4), .value_out(value_out), .value_valid(value_valid),
        .digit_count(digit_count), .msg_active(msg_active)
    );

    typedef struct {
        int          cyc;
        logic [15:0] h;
        logic [3:0]  p;
        logic        chk_p;
        logic [2:0]  cnt;
        logic        ma;
        string       name;
    } exp_t;

    exp_t        disp_q[$];
    logic [15:0] val_q[$];
    logic [15:0] ack_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic        done = 1'b0;
    logic        fin = 1'b0;
    exp_t        me;
    logic [15:0] mv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: compares display snapshots, enter pulses and message acks against queued expectations
    always @(negedge clk) begin
        if (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
            me = disp_q.pop_front();
            checks++;
            if (me.cyc == cyc && {hexa3, hexa2, hexa1, hexa0} === me.h && digit_count === me.cnt
                && msg_active === me.ma && (!me.chk_p || puntos4 === me.p))
                passes++;
            else
                $display("FAIL %s @%0d: got h=%h p=%b cnt=%0d ma=%b, want h=%h p=%b(chk=%b) cnt=%0d ma=%b at %0d",
                         me.name, cyc, {hexa3, hexa2, hexa1, hexa0}, puntos4, digit_count, msg_active,
                         me.h, me.p, me.chk_p, me.cnt, me.ma, me.cyc);
        end
        if (value_valid === 1'b1) begin
            checks++;
            if (val_q.size() == 0) begin
                $display("FAIL value_pulse @%0d: unexpected value_valid, value_out=%h", cyc, value_out);
            end else begin
                mv = val_q.pop_front();
                if (value_out === mv) passes++;
                else $display("FAIL value_out @%0d: got %h want %h", cyc, value_out, mv);
            end
        end
        if (msg_ack === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin
                $display("FAIL msg_ack @%0d: unexpected ack", cyc);
            end else begin
                mv = ack_q.pop_front();
                if ({hexa3, hexa2, hexa1, hexa0} === mv && msg_active === 1'b1) passes++;
                else $display("FAIL msg_ack @%0d: shown %h active=%b want %h active=1",
                              cyc, {hexa3, hexa2, hexa1, hexa0}, msg_active, mv);
            end
        end
        if (done && !fin) begin
            fin = 1'b1;
            checks += 3;
            if (disp_q.size() == 0) passes++;
            else $display("FAIL disp_pending: got %0d unchecked, want 0", disp_q.size());
            if (val_q.size() == 0) passes++;
            else $display("FAIL value_missing: got %0d pulses missing, want 0", val_q.size());
            if (ack_q.size() == 0) passes++;
            else $display("FAIL ack_missing: got %0d acks missing, want 0", ack_q.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input logic [15:0] h, input logic [3:0] p,
                             input logic chk_p, input logic [2:0] cnt, input logic ma, input string nm);
        exp_t e;
        e.cyc = c; e.h = h; e.p = p; e.chk_p = chk_p; e.cnt = cnt; e.ma = ma; e.name = nm;
        disp_q.push_back(e);
    endtask

    task automatic key(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = 5'h00;
    endtask

    task automatic kexp(input logic [4:0] c, input logic [15:0] h, input logic [3:0] p,
                        input logic [2:0] cnt, input string nm);
        key(c);
        expect_at(cyc, h, p, 1'b1, cnt, 1'b0, nm);
    endtask

    task automatic msg(input logic [15:0] d);
        ack_q.push_back(d);
        msg_req  = 1'b1;
        msg_data = d;
        tick();
        msg_req  = 1'b0;
        msg_data = 16'h0000;
    endtask

    int r, e, f, g;

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 5'h00; msg_req = 1'b0; msg_data = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        r = cyc;
        expect_at(r,     16'h0000, 4'b0001, 1'b1, 3'd0, 1'b0, "reset");
        expect_at(r + 3, 16'h0000, 4'b0001, 1'b1, 3'd0, 1'b0, "blink_hold");
        expect_at(r + 4, 16'h0000, 4'b0000, 1'b1, 3'd0, 1'b0, "blink_toggle");
        repeat (5) tick();
        key(5'h01);
        expect_at(r + 6,  16'h0001, 4'b0001, 1'b1, 3'd1, 1'b0, "blink_key_force");
        expect_at(r + 9,  16'h0001, 4'b0001, 1'b1, 3'd1, 1'b0, "blink_restart_hold");
        expect_at(r + 10, 16'h0001, 4'b0000, 1'b1, 3'd1, 1'b0, "blink_restart_toggle");
        repeat (4) tick();

        kexp(5'h10, 16'h0000, 4'b0001, 3'd0, "clear0");
        kexp(5'h01, 16'h0001, 4'b0001, 3'd1, "digit1");
        kexp(5'h02, 16'h0012, 4'b0001, 3'd2, "digit2");
        kexp(5'h03, 16'h0123, 4'b0001, 3'd3, "digit3");
        kexp(5'h04, 16'h1234, 4'b0000, 3'd4, "digit4_full");
        kexp(5'h05, 16'h1234, 4'b0000, 3'd4, "digit_when_full");
        kexp(5'h11, 16'h0123, 4'b0001, 3'd3, "bksp1");
        kexp(5'h11, 16'h0012, 4'b0001, 3'd2, "bksp2");
        kexp(5'h10, 16'h0000, 4'b0001, 3'd0, "clear");
        kexp(5'h11, 16'h0000, 4'b0001, 3'd0, "bksp_empty");
        kexp(5'h15, 16'h0000, 4'b0001, 3'd0, "undef_cmd");
        kexp(5'h0A, 16'h000A, 4'b0001, 3'd1, "digitA");
        kexp(5'h0B, 16'h00AB, 4'b0001, 3'd2, "digitB");
        val_q.push_back(16'h00AB);
        kexp(5'h12, 16'h0000, 4'b0001, 3'd0, "enter");
        val_q.push_back(16'h0000);
        kexp(5'h12, 16'h0000, 4'b0001, 3'd0, "enter_empty");
        kexp(5'h01, 16'h0001, 4'b0001, 3'd1, "pre_msg1");
        kexp(5'h02, 16'h0012, 4'b0001, 3'd2, "pre_msg2");

        msg(16'hE0F1);
        e = cyc;
        expect_at(e, 16'hE0F1, 4'b1111, 1'b1, 3'd2, 1'b1, "msg_shown");
        key(5'h07);
        expect_at(e + 1, 16'hE0F1, 4'b1111, 1'b1, 3'd2, 1'b1, "msg_key_dropped");
        expect_at(e + 7, 16'hE0F1, 4'b1111, 1'b1, 3'd2, 1'b1, "msg_last_cycle");
        expect_at(e + 8, 16'h0012, 4'b0000, 1'b0, 3'd2, 1'b0, "msg_expired");
        repeat (7) tick();

        msg(16'hC0DE);
        f = cyc;
        expect_at(f + 2, 16'hC0DE, 4'b1111, 1'b1, 3'd2, 1'b1, "msg2_shown");
        repeat (2) tick();
        msg(16'h5555);
        expect_at(f + 3,  16'h5555, 4'b1111, 1'b1, 3'd2, 1'b1, "msg_restart");
        expect_at(f + 10, 16'h5555, 4'b1111, 1'b1, 3'd2, 1'b1, "msg_restart_last");
        expect_at(f + 11, 16'h0012, 4'b0000, 1'b0, 3'd2, 1'b0, "msg_restart_expired");
        repeat (8) tick();

        kexp(5'h10, 16'h0000, 4'b0001, 3'd0, "clear_before_same");
        ack_q.push_back(16'h1234);
        key_valid = 1'b1; key_code = 5'h09; msg_req = 1'b1; msg_data = 16'h1234;
        tick();
        key_valid = 1'b0; key_code = 5'h00; msg_req = 1'b0; msg_data = 16'h0000;
        g = cyc;
        expect_at(g,     16'h1234, 4'b1111, 1'b1, 3'd1, 1'b1, "same_cycle_msg");
        expect_at(g + 8, 16'h0009, 4'b0000, 1'b0, 3'd1, 1'b0, "same_cycle_key");
        repeat (10) tick();

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/display_entry_ctrl.md
Name: display_entry_ctrl

Overview:
- Sequencer and arbiter in front of the Timemultiplexhexa 4-digit seven-segment multiplexer.
- Turns keypad events into a 4-digit hex entry buffer with a blinking cursor dot.
- Shares the display with a system message source: a message preempts the entry view for a fixed hold time, then the entry view returns.
- Drives hexa3..hexa0 and puntos4 of the multiplexer directly. Hands completed entries to downstream logic.

Parameters:
- BLINK_DIV, 25000000, clk cycles per cursor-dot toggle. Minimum 2.
- MSG_HOLD, 100000000, clk cycles a message stays on the display. Minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code is valid while high
- key_code  in  5  bit4=0: hex digit in [3:0]; 5'h10 clear; 5'h11 backspace; 5'h12 enter; other commands ignored
- msg_req  in  1  message request; level, sampled every cycle
- msg_data  in  16  message digits; [15:12] maps to hexa3
- msg_ack  out  1  one-cycle pulse when a message is accepted
- hexa3, hexa2, hexa1, hexa0  out  4 each  digit values to the multiplexer
- puntos4  out  4  decimal points, 1 = lit, bit i = digit i
- value_out  out  16  last entered value
- value_valid  out  1  one-cycle pulse when value_out updates
- digit_count  out  3  digits currently in the entry buffer, 0..4
- msg_active  out  1  high while the message view is shown

Behaviour:
- Reset: state ENTRY; entry buffer, count, value_out, hexa* all 0; value_valid=0, msg_ack=0, msg_active=0; blink phase=1, blink counter=0; puntos4=4'b0001.
- Reset mid-message: the message is dropped and the entry buffer is cleared.
- All state is registered. Outputs reflect an event on the first cycle after the sampling edge (1-cycle latency).

State ENTRY (msg_active=0, hexa3..0 = entry[15:0]):
- Digit, count<4: entry <= {entry[11:0], code[3:0]}; count+1.
- Digit, count==4 (full): ignored; buffer unchanged.
- Backspace, count>0: entry <= {4'h0, entry[15:4]}; count-1.
- Backspace, count==0: ignored.
- Clear: entry <= 0; count <= 0.
- Enter: value_out <= entry; value_valid=1 for exactly one cycle; entry and count cleared. Enter with count==0 still fires and outputs 16'h0000.
- Undefined commands (5'h13..5'h1F): ignored.
- Cursor dot, count<4: puntos4 = {3'b000, blink}.
- Cursor dot, count==4: puntos4 = 4'b0000.
- Blink: toggles when the blink counter reaches BLINK_DIV-1, and the counter wraps to 0.
- Any accepted (non-ignored) key forces blink=1 and counter=0.
- msg_req=1: latch msg_data; msg_ack pulses one cycle; load hold counter with MSG_HOLD-1; go to MSG.
- Key and msg_req in the same cycle: apply the key to the buffer and accept the message on the same edge.

State MSG (msg_active=1, hexa3..0 = latched message, puntos4=4'b1111):
- key_valid is dropped, with no queuing. The entry buffer and count are preserved.
- The hold counter decrements each cycle.
- At counter 0 with msg_req=0: return to ENTRY. The message is shown for exactly MSG_HOLD cycles.
- msg_req=1 in any MSG cycle: re-latch msg_data; msg_ack pulses; hold counter reloads to MSG_HOLD-1. This restarts the message and takes priority over expiry.
- A requester holding msg_req high keeps the display in MSG and receives msg_ack every cycle. Requesters drop msg_req on seeing ack.
- Blink counter keeps running in MSG, but is not visible.
- digit_count always shows the entry count, in both states.

Test Plan (BLINK_DIV=4, MSG_HOLD=8):
- Reset, then keys 1,2,3,4 -> hexa3..0 = 1,2,3,4; digit_count=4; puntos4=0000. Key 5 -> unchanged.
- Buffer 1234; backspace x2 -> hexa = 0,0,1,2, count=2. Clear -> all 0, count=0. Backspace at count 0 -> no change.
- Keys A,B then enter -> value_out=16'h00AB; value_valid high exactly 1 cycle; hexa all 0; count=0. Enter on empty -> value_out=0000 with a pulse.
- Idle after reset -> puntos4 bit0 toggles every 4 cycles. A key mid-period -> bit0=1 the next cycle, and the period restarts.
- Buffer 0012; one-cycle msg_req with msg_data=16'hE0F1 -> msg_ack 1 cycle; hexa=E,0,F,1; puntos4=1111; key 7 during MSG is dropped. After 8 cycles -> hexa=0,0,1,2, count=2.
- msg_req pulsed again 3 cycles into MSG with data 16'h5555 -> new ack; shows 5555 for 8 more cycles. Same-cycle key 9 + msg_req in ENTRY with empty buffer -> MSG entered; after expiry hexa0=9.
